// File: rtl/uart_cfg_pkg.sv
// Shared constants, state encoding and helpers for the UART config controller.
package uart_cfg_pkg;

  // Frame bytes
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  // CMD byte fields: read/write flag and the LSB of the register address
  localparam int unsigned CMD_RW_BIT   = 7;
  localparam int unsigned CMD_ADDR_LSB = 0;

  localparam int unsigned ERR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_CHK,
    ST_RESP
  } state_e;

  // Saturating increment for the error counter
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/uart_cfg_timeout.sv
// Inter-byte timeout counter.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : clear the count (takes priority)
//   i_en           : count this cycle
//   o_tc_c         : terminal count reached while enabled (combinational)
module uart_cfg_timeout #(
  parameter  int unsigned TIMEOUT_CYCLES = 100000,
  localparam int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fires on the TIMEOUT_CYCLES-th consecutive enabled cycle
  assign o_tc_c = i_en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr || o_tc_c) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cfg_ctrl.sv
// Config-frame parser behind uart_rx: SYNC, CMD, [DATA], CHK -> register
// write/read with a one-byte ACK/NAK/read-data response.
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_data, i_dv          : received byte and its one-cycle strobe
//   o_tx_data, o_tx_valid : response byte, held until i_tx_ready
//   o_cfg                 : flattened config registers, reg k at [k*WIDTH +: WIDTH]
//   o_cfg_upd, o_cfg_idx  : one-cycle write pulse and last written index
//   o_err_cnt             : saturating frame-error count
module uart_cfg_ctrl
  import uart_cfg_pkg::*;
#(
  parameter  int unsigned CLK_HZ         = 50000000,
  parameter  int unsigned WIDTH          = 8,
  parameter  int unsigned NUM_REGS       = 4,
  parameter  int unsigned TIMEOUT_CYCLES = 100000,
  localparam int unsigned ADDR_W         = $clog2(NUM_REGS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [WIDTH-1:0]          i_data,
  input  logic                      i_dv,
  output logic [WIDTH-1:0]          o_tx_data,
  output logic                      o_tx_valid,
  input  logic                      i_tx_ready,
  output logic [NUM_REGS*WIDTH-1:0] o_cfg,
  output logic                      o_cfg_upd,
  output logic [ADDR_W-1:0]         o_cfg_idx,
  output logic [ERR_W-1:0]          o_err_cnt
);

  // Elaboration-time parameter sanity check
  if (CLK_HZ == 0 || WIDTH != 8 || NUM_REGS < 2 || NUM_REGS > 16 ||
      (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_param_check
    $error("uart_cfg_ctrl: unsupported parameter set");
  end

  state_e                         state_q, state_d;
  logic [WIDTH-1:0]               cmd_q, cmd_d;
  logic [WIDTH-1:0]               data_q, data_d;
  logic [NUM_REGS-1:0][WIDTH-1:0] cfg_q, cfg_d;
  logic                           cfg_upd_q, cfg_upd_d;
  logic [ADDR_W-1:0]              cfg_idx_q, cfg_idx_d;
  logic [WIDTH-1:0]               tx_data_q, tx_data_d;
  logic                           tx_valid_q, tx_valid_d;
  logic [ERR_W-1:0]               err_cnt_q, err_cnt_d;

  logic              to_en_c, to_clr_c, to_fire_c;
  logic [ADDR_W-1:0] addr_c;
  logic              is_wr_c, rsv_ok_c, chk_ok_c;

  // Timeout only runs inside a frame on cycles without a byte
  assign to_en_c  = (state_q inside {ST_CMD, ST_DATA, ST_CHK}) && !i_dv;
  assign to_clr_c = !to_en_c;

  uart_cfg_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (to_clr_c),
    .i_en    (to_en_c),
    .o_tc_c  (to_fire_c)
  );

  // CMD decode and checksum; i_data is the CHK byte when evaluated
  assign addr_c   = cmd_q[CMD_ADDR_LSB +: ADDR_W];
  assign is_wr_c  = cmd_q[CMD_RW_BIT];
  assign rsv_ok_c = (cmd_q[CMD_RW_BIT-1:CMD_ADDR_LSB+ADDR_W] == '0);
  assign chk_ok_c = is_wr_c ? (i_data == (cmd_q ^ data_q)) : (i_data == cmd_q);

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    cfg_d      = cfg_q;
    cfg_upd_d  = 1'b0;
    cfg_idx_d  = cfg_idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    err_cnt_d  = err_cnt_q;

    if (to_fire_c) begin
      // Abandon the frame silently apart from the error count
      state_d   = ST_IDLE;
      err_cnt_d = sat_inc(err_cnt_q);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_dv && i_data == WIDTH'(SYNC)) state_d = ST_CMD;
        end
        ST_CMD: begin
          if (i_dv) begin
            cmd_d   = i_data;
            state_d = i_data[CMD_RW_BIT] ? ST_DATA : ST_CHK;
          end
        end
        ST_DATA: begin
          if (i_dv) begin
            data_d  = i_data;
            state_d = ST_CHK;
          end
        end
        ST_CHK: begin
          if (i_dv) begin
            state_d    = ST_RESP;
            tx_valid_d = 1'b1;
            if (chk_ok_c && rsv_ok_c) begin
              if (is_wr_c) begin
                cfg_d[addr_c] = data_q;
                cfg_upd_d     = 1'b1;
                cfg_idx_d     = addr_c;
                tx_data_d     = WIDTH'(ACK);
              end else begin
                tx_data_d = cfg_q[addr_c];
              end
            end else begin
              tx_data_d = WIDTH'(NAK);
              err_cnt_d = sat_inc(err_cnt_q);
            end
          end
        end
        ST_RESP: begin
          // Incoming bytes are dropped here
          if (i_tx_ready) begin
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      data_q     <= '0;
      cfg_q      <= '0;
      cfg_upd_q  <= 1'b0;
      cfg_idx_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      cfg_q      <= cfg_d;
      cfg_upd_q  <= cfg_upd_d;
      cfg_idx_q  <= cfg_idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_cfg      = cfg_q;
  assign o_cfg_upd  = cfg_upd_q;
  assign o_cfg_idx  = cfg_idx_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Directed bench for uart_cfg_ctrl: frame table plus timeout, backpressure,
// reset and error-saturation sequences.
module tb_uart_cfg_ctrl;

  localparam int unsigned TO = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data;
  logic        dv;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] cfg;
  logic        cfg_upd;
  logic [1:0]  cfg_idx;
  logic [7:0]  err_cnt;

  uart_cfg_ctrl #(
    .CLK_HZ         (50000000),
    .WIDTH          (8),
    .NUM_REGS       (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_data     (data),
    .i_dv       (dv),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_cfg      (cfg),
    .o_cfg_upd  (cfg_upd),
    .o_cfg_idx  (cfg_idx),
    .o_err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Event recorder: accepted responses and write pulses
  int unsigned tx_cnt   = 0;
  int unsigned upd_cnt  = 0;
  logic [7:0]  last_tx  = 8'h00;
  logic [1:0]  last_idx = 2'd0;
  always @(posedge clk) begin
    if (tx_valid && tx_ready) begin
      tx_cnt++;
      last_tx = tx_data;
    end
    if (cfg_upd) begin
      upd_cnt++;
      last_idx = cfg_idx;
    end
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; dv is high for exactly one posedge, then gap idle cycles
  task automatic send_byte(input logic [7:0] b, input int gap);
    data = b;
    dv   = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_tx(input int unsigned base, output bit got);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (tx_cnt != base) got = 1'b1;
    end
  endtask

  typedef struct {
    logic [0:7][7:0] frame;
    int              len;
    logic [7:0]      tx;
    int unsigned     upd;
    logic [1:0]      idx;
    logic [7:0]      err;
    logic [31:0]     cfg;
  } vec_t;

  vec_t        vt[8];
  int unsigned tb_base, ub_base;
  bit          got;
  bit          stable;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{64'hA5813CBD_00000000, 4, 8'h06, 1, 2'd1, 8'd0, 32'h0000_3C00};
    vt[1] = '{64'hA5010100_00000000, 3, 8'h3C, 0, 2'd1, 8'd0, 32'h0000_3C00};
    vt[2] = '{64'hA5821000_00000000, 4, 8'h15, 0, 2'd1, 8'd1, 32'h0000_3C00};
    vt[3] = '{64'hA5C000C0_00000000, 4, 8'h15, 0, 2'd1, 8'd2, 32'h0000_3C00};
    vt[4] = '{64'h00FF5AA5_837FFC00, 7, 8'h06, 1, 2'd3, 8'd2, 32'h7F00_3C00};
    vt[5] = '{64'hA5A5A5A5_00000000, 4, 8'h15, 0, 2'd3, 8'd3, 32'h7F00_3C00};
    vt[6] = '{64'hA5030300_00000000, 3, 8'h7F, 0, 2'd3, 8'd3, 32'h7F00_3C00};
    vt[7] = '{64'hA5020200_00000000, 3, 8'h00, 0, 2'd3, 8'd3, 32'h7F00_3C00};

    rst_n    = 1'b0;
    dv       = 1'b0;
    data     = 8'h00;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset cfg",      cfg,      32'h0);
    check("reset tx_valid", tx_valid, 32'h0);
    check("reset tx_data",  tx_data,  32'h0);
    check("reset err_cnt",  err_cnt,  32'h0);
    check("reset cfg_upd",  cfg_upd,  32'h0);
    check("reset cfg_idx",  cfg_idx,  32'h0);

    // Table of complete frames
    for (int v = 0; v < 8; v++) begin
      tb_base = tx_cnt;
      ub_base = upd_cnt;
      for (int b = 0; b < vt[v].len; b++) send_byte(vt[v].frame[b], 1);
      wait_tx(tb_base, got);
      repeat (2) @(negedge clk);
      check($sformatf("v%0d tx count", v), tx_cnt - tb_base, 32'd1);
      check($sformatf("v%0d tx byte", v),  last_tx,          vt[v].tx);
      check($sformatf("v%0d upd count", v), upd_cnt - ub_base, vt[v].upd);
      check($sformatf("v%0d cfg_idx", v),  cfg_idx,          vt[v].idx);
      check($sformatf("v%0d err_cnt", v),  err_cnt,          vt[v].err);
      check($sformatf("v%0d cfg", v),      cfg,              vt[v].cfg);
      check($sformatf("v%0d tx_valid low", v), tx_valid,     32'h0);
    end
    check("write pulse idx", last_idx, 32'd3);

    // Byte arriving on the cycle the timeout would fire wins
    tb_base = tx_cnt;
    send_byte(8'hA5, 0);
    send_byte(8'h82, TO - 1);
    send_byte(8'h66, 0);
    send_byte(8'hE4, 1);
    wait_tx(tb_base, got);
    repeat (2) @(negedge clk);
    check("to-edge tx",   last_tx, 32'h06);
    check("to-edge cfg",  cfg,     32'h7F66_3C00);
    check("to-edge err",  err_cnt, 32'd3);

    // Full timeout: no response, error counted, trailing bytes ignored in IDLE
    tb_base = tx_cnt;
    send_byte(8'hA5, 0);
    send_byte(8'h82, TO);
    send_byte(8'h55, 1);
    send_byte(8'hD7, 1);
    repeat (20) @(negedge clk);
    check("timeout no tx", tx_cnt - tb_base, 32'd0);
    check("timeout err",   err_cnt,          32'd4);
    check("timeout cfg",   cfg,              32'h7F66_3C00);
    tb_base = tx_cnt;
    send_byte(8'hA5, 1);
    send_byte(8'h82, 1);
    send_byte(8'h55, 1);
    send_byte(8'hD7, 1);
    wait_tx(tb_base, got);
    repeat (2) @(negedge clk);
    check("post-timeout tx",  last_tx, 32'h06);
    check("post-timeout cfg", cfg,     32'h7F55_3C00);

    // Backpressure: response held, extra bytes dropped
    tx_ready = 1'b0;
    tb_base  = tx_cnt;
    send_byte(8'hA5, 1);
    send_byte(8'h80, 1);
    send_byte(8'h11, 1);
    send_byte(8'h91, 1);
    check("bp valid", tx_valid, 32'h1);
    stable = 1'b1;
    send_byte(8'hA5, 1);
    send_byte(8'h81, 1);
    send_byte(8'h3C, 1);
    send_byte(8'hBD, 1);
    for (int i = 0; i < 42; i++) begin
      if (tx_valid !== 1'b1 || tx_data !== 8'h06) stable = 1'b0;
      @(negedge clk);
    end
    check("bp stable",      stable,           32'h1);
    check("bp no accept",   tx_cnt - tb_base, 32'd0);
    check("bp err",         err_cnt,          32'd4);
    tx_ready = 1'b1;
    @(negedge clk);
    check("bp valid drop",  tx_valid,         32'h0);
    repeat (10) @(negedge clk);
    check("bp single tx",   tx_cnt - tb_base, 32'd1);
    check("bp tx byte",     last_tx,          32'h06);
    check("bp cfg",         cfg,              32'h7F55_3C11);

    // Asynchronous reset mid-frame
    tb_base = tx_cnt;
    ub_base = upd_cnt;
    send_byte(8'hA5, 0);
    send_byte(8'h81, 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst cfg",      cfg,      32'h0);
    check("arst err",      err_cnt,  32'h0);
    check("arst tx_data",  tx_data,  32'h0);
    check("arst tx_valid", tx_valid, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h3C, 0);
    send_byte(8'hBD, 1);
    repeat (30) @(negedge clk);
    check("arst no tx",  tx_cnt - tb_base,  32'd0);
    check("arst no upd", upd_cnt - ub_base, 32'd0);
    check("arst cfg after", cfg,            32'h0);

    // Error counter saturates at 0xFF
    for (int f = 0; f < 256; f++) begin
      tb_base = tx_cnt;
      send_byte(8'hA5, 1);
      send_byte(8'h00, 1);
      send_byte(8'h01, 1);
      wait_tx(tb_base, got);
      if (f == 253) check("sat err 254", err_cnt, 32'hFE);
    end
    repeat (2) @(negedge clk);
    check("sat err", err_cnt, 32'hFF);
    check("sat nak", last_tx, 32'h15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
